// File: rtl/dino_pkg.sv
// Shared types and default geometry for the dino jump controller.
package dino_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RISE,
        ST_HOLD,
        ST_FALL,
        ST_DEAD
    } jump_state_e;

    localparam int GROUND_Y_DFLT    = 160;
    localparam int DINO_H_DFLT      = 71;
    localparam int JUMP_HEIGHT_DFLT = 60;

endpackage

// File: rtl/key_debounce.sv
// Jump key synchronizer, optional counter filter and press edge detector.
// Filter is built only when DINO_JUMP_DEBOUNCE_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic [1:0] sync;
    logic       level;
    logic       level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], key_n};
    end

`ifdef DINO_JUMP_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // A new level is taken only after it has differed for a full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync[1] == level) begin
            cnt   <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^DEBOUNCE_CYCLES;
    assign level      = sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) level_q <= 1'b1;
        else      level_q <= level;
    end

    assign press = level_q & ~level;

endmodule

// File: rtl/dino_jump_ctrl.sv
// Dino jump state machine with registered sprite row outputs.
// Key filtering depends on DINO_JUMP_DEBOUNCE_EN (see key_debounce).
module dino_jump_ctrl #(
    parameter int GROUND_Y        = dino_pkg::GROUND_Y_DFLT,
    parameter int DINO_H          = dino_pkg::DINO_H_DFLT,
    parameter int JUMP_HEIGHT     = dino_pkg::JUMP_HEIGHT_DFLT,
    parameter int RISE_STEP       = 4,
    parameter int FALL_STEP       = 4,
    parameter int HOLD_FRAMES     = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       frame_tick,
    input  logic       break_game,
    output logic       jump_active,
    output logic [9:0] dino_ver_from,
    output logic [9:0] dino_ver_to,
    output logic       dead
);

    import dino_pkg::*;

    jump_state_e state;
    jump_state_e state_nx;
    logic [5:0]  off;
    logic [5:0]  off_nx;
    logic [7:0]  hold;
    logic [7:0]  hold_nx;
    logic        press;
    logic [6:0]  rise_sum;
    logic [7:0]  hold_inc;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_n),
        .press(press)
    );

    assign rise_sum = {1'b0, off} + 7'(RISE_STEP);
    assign hold_inc = hold + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            off   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            off   <= off_nx;
            hold  <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        off_nx   = off;
        hold_nx  = hold;
        if (break_game) begin
            state_nx = ST_DEAD;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (press) state_nx = ST_RISE;
                end
                ST_RISE: begin
                    if (frame_tick) begin
                        if (rise_sum >= 7'(JUMP_HEIGHT)) begin
                            off_nx   = 6'(JUMP_HEIGHT);
                            hold_nx  = '0;
                            state_nx = ST_HOLD;
                        end else begin
                            off_nx = rise_sum[5:0];
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_tick) begin
                        hold_nx = hold_inc;
                        if (hold_inc == 8'(HOLD_FRAMES)) state_nx = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (frame_tick) begin
                        if ({1'b0, off} <= 7'(FALL_STEP)) begin
                            off_nx   = '0;
                            state_nx = ST_IDLE;
                        end else begin
                            off_nx = off - 6'(FALL_STEP);
                        end
                    end
                end
                ST_DEAD: begin
                    if (press) begin
                        off_nx   = '0;
                        hold_nx  = '0;
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    off_nx   = '0;
                    hold_nx  = '0;
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Renderer sees state and offset one clock late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_active   <= 1'b0;
            dead          <= 1'b0;
            dino_ver_from <= 10'(GROUND_Y);
            dino_ver_to   <= 10'(GROUND_Y + DINO_H);
        end else begin
            jump_active   <= (state == ST_RISE) || (state == ST_HOLD) ||
                             (state == ST_FALL);
            dead          <= (state == ST_DEAD);
            dino_ver_from <= 10'(GROUND_Y) - 10'(off);
            dino_ver_to   <= 10'(GROUND_Y) - 10'(off) + 10'(DINO_H);
        end
    end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl: default build plus a RISE_STEP=7 copy.
// Glitch expectation follows DINO_JUMP_DEBOUNCE_EN.
module tb_dino_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       break_game = 1'b0;
    logic       ja4, dead4, ja7, dead7;
    logic [9:0] from4, to4, from7, to7;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dino_jump_ctrl #(
        .DEBOUNCE_CYCLES(16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n),
        .frame_tick   (frame_tick),
        .break_game   (break_game),
        .jump_active  (ja4),
        .dino_ver_from(from4),
        .dino_ver_to  (to4),
        .dead         (dead4)
    );

    dino_jump_ctrl #(
        .RISE_STEP      (7),
        .DEBOUNCE_CYCLES(16)
    ) u_dut7 (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n),
        .frame_tick   (frame_tick),
        .break_game   (break_game),
        .jump_active  (ja7),
        .dino_ver_from(from7),
        .dino_ver_to  (to7),
        .dead         (dead7)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic press();
        @(negedge clk) key_n = 1'b0;
        repeat (40) @(negedge clk);
        key_n = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int exp7;
    int glitch_exp;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_from", from4, 160);
        chk("rst_to", to4, 231);
        chk("rst_ja", ja4, 0);
        chk("rst_dead", dead4, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // full jump; a second press during apex must be dropped
        press();
        chk("press_ja", ja4, 1);
        chk("press_from", from4, 160);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("rise4_%0d", k), from4, 160 - 4 * k);
            if (k <= 9) begin
                exp7 = (7 * k > 60) ? 60 : 7 * k;
                chk($sformatf("rise7_%0d", k), from7, 160 - exp7);
            end
        end
        chk("apex_to", to4, 171);
        for (int k = 16; k <= 21; k++) begin
            tick();
            chk($sformatf("hold_%0d", k), from4, 100);
            if (k == 16) press();
        end
        for (int k = 22; k <= 36; k++) begin
            tick();
            chk($sformatf("fall_%0d", k), from4, 100 + 4 * (k - 21));
        end
        chk("land_ja", ja4, 0);
        chk("land_to", to4, 231);
        ticks(4);
        chk("after_ja", ja4, 0);
        chk("after_from", from4, 160);
        chk("after7_ja", ja7, 0);
        chk("after7_from", from7, 160);

        // short key glitch
        @(negedge clk) key_n = 1'b0;
        repeat (5) @(negedge clk);
        key_n = 1'b1;
        repeat (30) @(negedge clk);
`ifdef DINO_JUMP_DEBOUNCE_EN
        glitch_exp = 0;
`else
        glitch_exp = 1;
`endif
        chk("glitch_ja", ja4, glitch_exp);
        chk("glitch_dead", dead4, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // collision mid-rise at offset 32
        press();
        ticks(8);
        chk("brk_pre", from4, 128);
        @(negedge clk) break_game = 1'b1;
        repeat (2) @(negedge clk);
        chk("brk_dead", dead4, 1);
        chk("brk_from", from4, 128);
        chk("brk_ja", ja4, 0);
        chk("brk7_from", from7, 104);
        tick();
        chk("brk_tick", from4, 128);
        @(negedge clk) break_game = 1'b0;
        repeat (2) @(negedge clk);
        chk("brk_stay", dead4, 1);
        press();
        chk("rev_dead", dead4, 0);
        chk("rev_from", from4, 160);
        chk("rev_to", to4, 231);
        chk("rev_ja", ja4, 0);

        // async reset during fall at offset 20
        press();
        ticks(31);
        chk("fall20", from4, 140);
        chk("fall20_ja", ja4, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_from", from4, 160);
        chk("arst_to", to4, 231);
        chk("arst_ja", ja4, 0);
        @(negedge clk) rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_ja", ja4, 0);
        chk("post_from", from4, 160);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dino_jump_ctrl.md
DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 SHALL have parameter GROUND_Y, default 160, meaning dino top row when on ground.
REQ-002 SHALL have parameter DINO_H, default 71, meaning sprite height minus one in rows.
REQ-003 SHALL have parameter JUMP_HEIGHT, default 60, meaning maximum upward offset in rows.
REQ-004 SHALL have parameter RISE_STEP, default 4, meaning rows gained per frame while rising.
REQ-005 SHALL have parameter FALL_STEP, default 4, meaning rows lost per frame while falling.
REQ-006 SHALL have parameter HOLD_FRAMES, default 6, meaning frames spent at apex.
REQ-007 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning stable clocks required to accept a key level.
REQ-008 SHALL have port clk, input, 1, system clock.
REQ-009 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port key_n, input, 1, raw asynchronous jump button, low = pressed.
REQ-011 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-012 SHALL have port break_game, input, 1, game-over level from collision logic.
REQ-013 SHALL have port jump_active, output, 1, high while airborne; drives renderer jump flag.
REQ-014 SHALL have port dino_ver_from, output, 10, sprite top row.
REQ-015 SHALL have port dino_ver_to, output, 10, sprite bottom row.
REQ-016 SHALL have port dead, output, 1, high in DEAD state.

Function
REQ-017 SHALL pass key_n through a 2-flop synchronizer, then generate a one-cycle press pulse on the debounced high-to-low transition.
REQ-018 SHALL implement FSM states IDLE, RISE, HOLD, FALL, DEAD, held in a 6-bit offset register and 8-bit hold counter.
REQ-019 IDLE: press and break_game low -> RISE; offset stays 0 even if frame_tick coincides.
REQ-020 RISE: on frame_tick offset = min(offset+RISE_STEP, JUMP_HEIGHT); when the new offset equals JUMP_HEIGHT -> HOLD, hold counter cleared.
REQ-021 HOLD: hold counter increments on frame_tick; on the tick where it reaches HOLD_FRAMES -> FALL.
REQ-022 FALL: on frame_tick offset = max(offset-FALL_STEP, 0), saturating; when the new offset is 0 -> IDLE.
REQ-023 Presses in RISE, HOLD and FALL SHALL be discarded, not queued.
REQ-024 break_game high in any state SHALL force DEAD next cycle, offset frozen; break_game wins over a simultaneous press or frame_tick.
REQ-025 DEAD: press with break_game low -> IDLE, offset cleared to 0.
REQ-026 Outputs SHALL be registered from state and offset, lagging them by exactly one clock.
REQ-027 Output values: dino_ver_from = GROUND_Y - offset; dino_ver_to = dino_ver_from + DINO_H; jump_active = state in {RISE, HOLD, FALL}; dead = state is DEAD.
REQ-028 frame_tick SHALL be ignored in IDLE and DEAD.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, offset 0, hold counter 0, debounce state released, jump_active 0, dead 0, dino_ver_from GROUND_Y, dino_ver_to GROUND_Y+DINO_H.
REQ-030 Reset mid-jump SHALL return the dino to ground with no press pulse emitted on release.

Configuration
REQ-031 With DINO_JUMP_DEBOUNCE_EN defined, the DEBOUNCE_CYCLES counter filter SHALL be present; without it, the synchronized key feeds the edge detector directly and DEBOUNCE_CYCLES is unused.

Structure
REQ-032 Package dino_pkg SHALL hold the jump-state enum type and the default geometry constants (GROUND_Y, DINO_H, JUMP_HEIGHT).
REQ-033 Synchronizer, debounce filter and edge detector SHALL form sub-module key_debounce, instantiated once.

Verification (defaults; DEBOUNCE_CYCLES set to 16 in the bench)
REQ-034 Single press, 40 frame_ticks -> jump_active rises; dino_ver_from reaches 100 and dino_ver_to 171 after 15 ticks; holds 6 ticks; returns to 160/231 after 15 more ticks; jump_active then 0.
REQ-035 key_n glitch low for 5 clocks (macro defined) -> no state change; same glitch with macro undefined -> RISE entered.
REQ-036 break_game asserted at offset 32 during RISE -> dead 1 and dino_ver_from frozen at 128; later press with break_game low -> IDLE, dino_ver_from 160.
REQ-037 Second press during HOLD -> ignored; exactly one jump completes.
REQ-038 rst pulsed low during FALL at offset 20 -> immediate IDLE outputs: 160/231, jump_active 0.
REQ-039 RISE_STEP=7 -> offset sequence 7, 14, ... 56, then 60 saturated; HOLD entered on the tick that produces 60.
